// File: rtl/cnn_stats_pkg.sv
// Shared definitions for the CNN statistics blocks: the variance FSM encoding
// and the accumulator width helpers.
package cnn_stats_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    function automatic int SUM_W(input int width, input int log2n);
        return width + log2n;
    endfunction

    function automatic int SQ_W(input int width, input int log2n);
        return 2 * width + log2n;
    endfunction

endpackage

// File: rtl/variance_acc_if.sv
// Bundle of the sample stream, sqrt handshake and result signals around variance_acc.
// master is the variance engine's view; slave is the surrounding system (source, sqrt, consumer).
interface variance_acc_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             sq_start;
  logic             sq_busy;
  logic             sq_valid;
  logic [WIDTH-1:0] sq_rad;
  logic [WIDTH-1:0] sq_root;
  logic [WIDTH-1:0] var_out;
  logic [WIDTH-1:0] sd_out;
  logic             out_valid;
  logic             ovf;

  modport master (
    input  s_valid, s_data, sq_busy, sq_valid, sq_root,
    output s_ready, sq_start, sq_rad, var_out, sd_out, out_valid, ovf
  );

  modport slave (
    output s_valid, s_data, sq_busy, sq_valid, sq_root,
    input  s_ready, sq_start, sq_rad, var_out, sd_out, out_valid, ovf
  );
endinterface

// File: rtl/stat_accum.sv
// Window accumulator: running sum and sum of squares of accepted samples,
// plus a sample counter that flags the last sample of each 2**LOG2N window.
module stat_accum
  import cnn_stats_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LOG2N = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                clr_i,
  input  logic                                acc_i,
  input  logic [WIDTH-1:0]                    data_i,
  output logic [SUM_W(WIDTH, LOG2N)-1:0]      sum_o,
  output logic [SQ_W(WIDTH, LOG2N)-1:0]       sumsq_o,
  output logic                                last_o
);
  localparam int SW  = SUM_W(WIDTH, LOG2N);
  localparam int SQW = SQ_W(WIDTH, LOG2N);

  logic [SW-1:0]      sum_q, sum_d;
  logic [SQW-1:0]     sumsq_q, sumsq_d;
  logic [LOG2N-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] sq_s;

  assign sq_s   = {{WIDTH{1'b0}}, data_i} * {{WIDTH{1'b0}}, data_i};
  assign last_o = acc_i && (cnt_q == {LOG2N{1'b1}});
  assign sum_o   = sum_q;
  assign sumsq_o = sumsq_q;

  // Next-state: clear wins over accumulate; the counter wraps naturally at N.
  always_comb begin
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      sum_d   = '0;
      sumsq_d = '0;
      cnt_d   = '0;
    end else if (acc_i) begin
      sum_d   = sum_q + SW'(data_i);
      sumsq_d = sumsq_q + SQW'(sq_s);
      cnt_d   = cnt_q + LOG2N'(1);
    end else begin
      sum_d   = sum_q;
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sum_q   <= '0;
      sumsq_q <= '0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/variance_acc.sv
// Streaming variance engine: accumulates windows, computes E[x^2]-E[x]^2 and drives
// an external sqrt core. Define VAR_CLAMP_EN to saturate overflowing variances.
module variance_acc
  import cnn_stats_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FBITS = 0,
  parameter int LOG2N = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  variance_acc_if.master bus
);
  localparam int SW  = SUM_W(WIDTH, LOG2N);
  localparam int SQW = SQ_W(WIDTH, LOG2N);

  state_e             state_q, state_d;
  logic               s_ready_s, sq_start_s, acc_s, clr_s, last_s;
  logic [SW-1:0]      sum_s;
  logic [SQW-1:0]     sumsq_s;
  logic [WIDTH-1:0]   mean_s;
  logic [2*WIDTH-1:0] msq_s, mm_s, d_s, v_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   res_s;
  logic [WIDTH-1:0]   rad_q, sd_q;
  logic               ovf_q, out_valid_q;

  assign acc_s = bus.s_valid && s_ready_s;
  assign clr_s = (state_q == ST_WAIT) && bus.sq_valid;

  stat_accum #(
    .WIDTH (WIDTH),
    .LOG2N (LOG2N)
  ) u_accum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (clr_s),
    .acc_i   (acc_s),
    .data_i  (bus.s_data),
    .sum_o   (sum_s),
    .sumsq_o (sumsq_s),
    .last_o  (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (acc_s && last_s) state_d = ST_CALC;
        else                 state_d = ST_ACCUM;
      end
      ST_CALC:  state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (!bus.sq_busy) state_d = ST_WAIT;
        else              state_d = ST_ISSUE;
      end
      ST_WAIT: begin
        if (bus.sq_valid) state_d = ST_ACCUM;
        else              state_d = ST_WAIT;
      end
      default:  state_d = ST_ACCUM;
    endcase
  end

  // FSM outputs; start fires in the first non-busy ISSUE cycle, which is also the exit cycle.
  always_comb begin
    s_ready_s  = 1'b0;
    sq_start_s = 1'b0;
    case (state_q)
      ST_ACCUM: s_ready_s  = 1'b1;
      ST_ISSUE: sq_start_s = !bus.sq_busy;
      default: begin
        s_ready_s  = 1'b0;
        sq_start_s = 1'b0;
      end
    endcase
  end

  // Variance datapath; floor(E[x^2]) >= floor(E[x])^2 so the difference never goes negative.
  always_comb begin
    mean_s = WIDTH'(sum_s >> LOG2N);
    msq_s  = (2*WIDTH)'(sumsq_s >> LOG2N);
    mm_s   = {{WIDTH{1'b0}}, mean_s} * {{WIDTH{1'b0}}, mean_s};
    d_s    = msq_s - mm_s;
    v_s    = d_s >> FBITS;
    ovf_s  = |v_s[2*WIDTH-1:WIDTH];
`ifdef VAR_CLAMP_EN
    if (ovf_s) res_s = {WIDTH{1'b1}};
    else       res_s = v_s[WIDTH-1:0];
`else
    res_s  = v_s[WIDTH-1:0];
`endif
  end

  // Result registers: radicand/variance latch in CALC, root latches on the accepted sqrt result.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rad_q       <= '0;
      sd_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (state_q == ST_CALC) begin
        rad_q <= res_s;
        ovf_q <= ovf_s;
      end
      if (clr_s) begin
        sd_q <= bus.sq_root;
      end
      out_valid_q <= clr_s;
    end
  end

  assign bus.s_ready   = s_ready_s;
  assign bus.sq_start  = sq_start_s;
  assign bus.sq_rad    = rad_q;
  assign bus.var_out   = rad_q;
  assign bus.sd_out    = sd_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule
